// File: rtl/hamming_univ_pkg.sv
// rtl/hamming_univ_pkg.sv - shared types, sizing and SEC-DED encoder for hamming_univ_reg
package hamming_univ_pkg;

  typedef enum logic [1:0] {
    MODE_SISO = 2'b00,
    MODE_SIPO = 2'b01,
    MODE_PISO = 2'b10,
    MODE_PIPO = 2'b11
  } mode_e;

  localparam int MAX_W       = 64;
  localparam int MAX_PAR     = 7;
  localparam int MAX_CW      = MAX_W + MAX_PAR + 1;
  localparam int OVERALL_POS = 0;

  function automatic int par_bits(input int width);
    int res;
    res = MAX_PAR;
    for (int r = MAX_PAR; r >= 1; r--)
      if ((1 << r) >= width + r + 1) res = r;
    return res;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Data fills non-power-of-two positions LSB-first; index 0 is overall parity.
  function automatic logic [MAX_CW-1:0] encode(input logic [MAX_W-1:0] data, input int width);
    logic [MAX_CW-1:0] c;
    logic              p;
    int                k;
    int                npar;
    int                cw;
    npar = par_bits(width);
    cw   = width + npar + 1;
    c    = '0;
    k    = 0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos < cw && !is_pow2(pos)) begin
        c[pos] = data[k];
        k++;
      end
    end
    for (int i = 0; i < MAX_PAR; i++) begin
      if (i < npar) begin
        p = 1'b0;
        for (int pos = 1; pos < MAX_CW; pos++)
          if (((pos >> i) & 1) == 1) p = p ^ c[pos];
        c[1 << i] = p;
      end
    end
    c[OVERALL_POS] = ^c;
    return c;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - combinational extended-Hamming SEC-DED decoder
module hamming_secded_dec import hamming_univ_pkg::*; #(
  parameter int  WIDTH = 8,
  localparam int PAR   = par_bits(WIDTH),
  localparam int CW    = WIDTH + PAR + 1
) (
  input  logic [CW-1:0]    cw,
  output logic [WIDTH-1:0] d,
  output logic             sec_err,
  output logic             ded_err
);

  logic [PAR-1:0] syn;
  logic           par_mis;
  logic [CW-1:0]  fixed;
  int             k;

  always_comb begin
    syn = '0;
    for (int i = 1; i < CW; i++)
      if (cw[i]) syn = syn ^ PAR'(i);
    par_mis = ^cw;
    sec_err = par_mis;
    ded_err = !par_mis && (syn != '0);
    // A zero syndrome with parity mismatch means only the overall parity bit flipped.
    fixed = cw;
    if (par_mis && syn != '0)
      for (int i = 1; i < CW; i++)
        if (PAR'(i) == syn) fixed[i] = ~fixed[i];
    d = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = fixed[pos];
        k++;
      end
    end
  end

endmodule

// File: rtl/hamming_univ_reg.sv
// rtl/hamming_univ_reg.sv - universal shift register with SEC-DED protected state, scrub and fault injection
module hamming_univ_reg import hamming_univ_pkg::*; #(
  parameter int  WIDTH = 8,
  parameter int  CNT_W = 8,
  localparam int PAR   = par_bits(WIDTH),
  localparam int CW    = WIDTH + PAR + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             shift_left,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             scrub_en,
  input  logic             inj_en,
  input  logic [CW-1:0]    inj_mask,
  input  logic             err_clr,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             sec_err,
  output logic             ded_err,
  output logic             ded_flag,
  output logic [CNT_W-1:0] sec_cnt
);

  logic [CW-1:0]    cw_q;
  logic [CW-1:0]    cw_next;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_data;
  logic             ins_bit;
  logic             commit;
  logic             count;

  hamming_secded_dec #(.WIDTH(WIDTH)) u_dec (
    .cw      (cw_q),
    .d       (d),
    .sec_err (sec_err),
    .ded_err (ded_err)
  );

  assign serial_out   = shift_left ? d[WIDTH-1] : d[0];
  assign parallel_out = d;

  always_comb begin
    ins_bit   = (mode_e'(mode) == MODE_PISO) ? 1'b0 : serial_in;
    shifted   = shift_left ? {d[WIDTH-2:0], ins_bit} : {ins_bit, d[WIDTH-1:1]};
    next_data = d;
    case (mode_e'(mode))
      MODE_SISO, MODE_SIPO: next_data = shifted;
      MODE_PISO:            next_data = load ? parallel_in : shifted;
      MODE_PIPO:            next_data = load ? parallel_in : d;
      default:              next_data = d;
    endcase
    // Idle cycles only rewrite the word when a correctable error is being scrubbed.
    commit  = enable | (scrub_en & sec_err & ~ded_err);
    count   = sec_err & commit;
    cw_next = commit ? CW'(encode(MAX_W'(enable ? next_data : d), WIDTH)) : cw_q;
    if (inj_en) cw_next = cw_next ^ inj_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q     <= '0;
      ded_flag <= 1'b0;
      sec_cnt  <= '0;
    end else begin
      cw_q     <= cw_next;
      ded_flag <= (ded_flag & ~err_clr) | ded_err;
      if (err_clr)
        sec_cnt <= CNT_W'(count);
      else if (count && sec_cnt != '1)
        sec_cnt <= sec_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_univ_reg.sv
// tb/tb_hamming_univ_reg.sv - self-checking bench for hamming_univ_reg
module tb_hamming_univ_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CW    = 13;
  localparam int DPOS[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [1:0]       mode;
  logic             shift_left;
  logic             load;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic             scrub_en;
  logic             inj_en;
  logic [CW-1:0]    inj_mask;
  logic             err_clr;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
  logic             sec_err;
  logic             ded_err;
  logic             ded_flag;
  logic [CNT_W-1:0] sec_cnt;

  hamming_univ_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .shift_left   (shift_left),
    .load         (load),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .scrub_en     (scrub_en),
    .inj_en       (inj_en),
    .inj_mask     (inj_mask),
    .err_clr      (err_clr),
    .serial_out   (serial_out),
    .parallel_out (parallel_out),
    .sec_err      (sec_err),
    .ded_err      (ded_err),
    .ded_flag     (ded_flag),
    .sec_cnt      (sec_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic       sl;
    logic       ld;
    logic       sin;
    logic [7:0] pin;
    logic       scrub;
    logic       inj;
    logic [12:0] mask;
    logic       clr;
    logic [7:0] e_pout;
    logic       e_sout;
    logic       e_sec;
    logic       e_ded;
    logic       e_flag;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];

  function automatic vec_t mk(input logic en, input logic [1:0] md, input logic sl, input logic ld,
                              input logic sin, input logic [7:0] pin, input logic scrub, input logic inj,
                              input logic [12:0] mask, input logic clr, input logic [7:0] e_pout,
                              input logic e_sout, input logic e_sec, input logic e_ded,
                              input logic e_flag, input logic [7:0] e_cnt);
    vec_t v;
    v.en = en; v.md = md; v.sl = sl; v.ld = ld; v.sin = sin; v.pin = pin;
    v.scrub = scrub; v.inj = inj; v.mask = mask; v.clr = clr;
    v.e_pout = e_pout; v.e_sout = e_sout; v.e_sec = e_sec; v.e_ded = e_ded;
    v.e_flag = e_flag; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enable = v.en; mode = v.md; shift_left = v.sl; load = v.ld; serial_in = v.sin;
    parallel_in = v.pin; scrub_en = v.scrub; inj_en = v.inj; inj_mask = v.mask; err_clr = v.clr;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] pout, input logic sout, input logic sec,
                            input logic ded, input logic flag, input logic [7:0] cnt);
    chk({tag, "_pout"}, 64'(parallel_out), 64'(pout));
    chk({tag, "_sout"}, 64'(serial_out), 64'(sout));
    chk({tag, "_sec"}, 64'(sec_err), 64'(sec));
    chk({tag, "_ded"}, 64'(ded_err), 64'(ded));
    chk({tag, "_flag"}, 64'(ded_flag), 64'(flag));
    chk({tag, "_cnt"}, 64'(sec_cnt), 64'(cnt));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    @(posedge clk); #1;
    check_outs(tag, v.e_pout, v.e_sout, v.e_sec, v.e_ded, v.e_flag, v.e_cnt);
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 13'h0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk) rst = 1'b0;
  endtask

  function automatic logic [7:0] dmask(input logic [12:0] m);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m[DPOS[i]];
    return r;
  endfunction

  function automatic logic [7:0] shf(input logic [7:0] v, input logic left, input logic b);
    return left ? {v[6:0], b} : {b, v[7:1]};
  endfunction

  // Reference model state: intended data plus the set of flipped codeword bits.
  logic [7:0]  m_data;
  logic [12:0] m_mask;
  logic [7:0]  m_cnt;
  logic        m_flag;

  initial begin
    do_reset();
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    tbl.push_back(mk(1, 3, 0, 1, 0, 8'hA5, 0, 0, 13'h0000, 0, 8'hA5, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0008, 0, 8'hA5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 0, 13'h0000, 0, 8'hA5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 0, 13'h0000, 0, 8'hA5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 1, 0, 13'h0000, 0, 8'hA5, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0001, 0, 8'hA5, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 1, 0, 13'h0000, 0, 8'hA5, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0018, 0, 8'hA4, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 1, 0, 13'h0000, 0, 8'hA4, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 3, 0, 1, 0, 8'h3C, 0, 0, 13'h0000, 0, 8'h3C, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 0, 13'h0000, 1, 8'h3C, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 8'hDB, 0, 0, 13'h0000, 0, 8'hDB, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h6D, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h36, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h1B, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h0D, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h06, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h03, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 8'hFF, 0, 0, 13'h0000, 0, 8'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 8'hFF, 0, 0, 13'h0000, 0, 8'h03, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 8'hFF, 0, 0, 13'h0000, 0, 8'h07, 0, 0, 0, 0, 0));
    foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a shift, checked before the next clock edge.
    drive(mk(1, 0, 1, 0, 1, 8'h00, 0, 0, 13'h0000, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1 check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk) rst = 1'b0;

    hand.push_back(mk(1, 3, 0, 1, 0, 8'h5A, 0, 0, 13'h0000, 0, 8'h5A, 0, 0, 0, 0, 0));
    hand.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0018, 0, 8'h5B, 1, 0, 1, 0, 0));
    hand.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 0, 13'h0000, 1, 8'h5B, 1, 0, 1, 1, 0));
    hand.push_back(mk(1, 3, 0, 1, 0, 8'h5A, 0, 0, 13'h0000, 0, 8'h5A, 0, 0, 0, 1, 0));
    hand.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0040, 1, 8'h5A, 0, 1, 0, 0, 0));
    hand.push_back(mk(0, 3, 0, 0, 0, 8'h00, 1, 0, 13'h0000, 1, 8'h5A, 0, 0, 0, 0, 1));
    hand.push_back(mk(0, 3, 0, 0, 0, 8'h00, 0, 1, 13'h0200, 0, 8'h5A, 0, 1, 0, 0, 1));
    hand.push_back(mk(1, 3, 1, 0, 0, 8'h00, 0, 0, 13'h0000, 0, 8'h5A, 0, 0, 0, 0, 2));
    foreach (hand[i]) run_vec($sformatf("hand%0d", i), hand[i]);

    do_reset();
    m_data = 8'h00; m_mask = 13'h0; m_cnt = 8'h00; m_flag = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int          w;
      logic        msec, mded, commit, cnt_ev;
      logic [7:0]  md, nd;
      logic [12:0] base_mask, im;
      vec_t        v;
      w    = $countones(m_mask);
      msec = (w == 1);
      mded = (w == 2);
      md   = mded ? (m_data ^ dmask(m_mask)) : m_data;
      v = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 3) != 0), 1'b0, 13'h0, 1'($urandom_range(0, 15) == 0),
             0, 0, 0, 0, 0, 0);
      commit = v.en || (v.scrub && msec && !mded);
      nd = md;
      if (v.en) begin
        case (v.md)
          2'd0, 2'd1: nd = shf(md, v.sl, v.sin);
          2'd2:       nd = v.ld ? v.pin : shf(md, v.sl, 1'b0);
          default:    nd = v.ld ? v.pin : md;
        endcase
      end
      base_mask = commit ? 13'h0 : m_mask;
      im = 13'h1 << $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) im = im | (13'h1 << $urandom_range(0, 12));
      v.mask = im;
      v.inj  = ($urandom_range(0, 2) == 0) && ($countones(base_mask ^ im) <= 2);
      cnt_ev = msec && commit;
      if (v.clr) begin
        m_flag = mded;
        m_cnt  = 8'(cnt_ev);
      end else begin
        m_flag = m_flag | mded;
        if (cnt_ev && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      if (commit) m_data = nd;
      m_mask = v.inj ? (base_mask ^ im) : base_mask;
      w  = $countones(m_mask);
      md = (w == 2) ? (m_data ^ dmask(m_mask)) : m_data;
      drive(v);
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", n), md, v.sl ? md[7] : md[0], 1'(w == 1), 1'(w == 2),
                 m_flag, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_univ_reg.md
Name: hamming_univ_reg

Overview:
- Parametrised universal shift register (SISO/SIPO/PISO/PIPO) with per-word extended-Hamming SEC-DED protection of its internal state.
- Successor to the fixed 8-bit Hamming register; generalises width and adds shift direction, background scrubbing, sticky double-error flag, saturating correction counter and a built-in fault-injection port, so verification no longer relies on force/release.
- Sits in the register datapath as a drop-in storage/serialiser element.

Parameters:
- WIDTH, 8, data width; legal range 4..64.
- CNT_W, 8, width of the correction counter.
- PAR, derived (do not override): smallest r with 2^r >= WIDTH+r+1. Equals 4 for WIDTH=8.
- CW, derived: WIDTH+PAR+1, the stored codeword width. Equals 13 for WIDTH=8.

Ports:
- clk, input, 1, clock (rising edge).
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, operation enable.
- mode, input, 2, 00 SISO, 01 SIPO, 10 PISO, 11 PIPO.
- shift_left, input, 1, 0 = shift toward LSB with serial_in entering at the MSB; 1 = shift toward MSB with serial_in entering at the LSB.
- load, input, 1, parallel load (PISO/PIPO only).
- serial_in, input, 1, serial data.
- parallel_in, input, WIDTH, parallel data.
- scrub_en, input, 1, allow writeback of corrected word while idle.
- inj_en, input, 1, apply fault mask this cycle.
- inj_mask, input, CW, bits XORed into the stored codeword.
- err_clr, input, 1, clear ded_flag and sec_cnt.
- serial_out, output, 1, outgoing bit of the corrected data.
- parallel_out, output, WIDTH, corrected data.
- sec_err, output, 1, single error present in the stored word (combinational).
- ded_err, output, 1, double error present (combinational).
- ded_flag, output, 1, sticky registered DED indicator.
- sec_cnt, output, CNT_W, saturating count of committed corrections.

Behaviour:
- Codeword layout: index 0 holds overall parity. Indices 1..CW-1 are Hamming positions, with parity at powers of two. Data bits fill the remaining positions LSB-first (WIDTH=8: positions 3,5,6,7,9,10,11,12).
- Reset: cw=0 (valid encoding of data 0), ded_flag=0, sec_cnt=0. Consequently parallel_out=0, serial_out=0, sec_err=0, ded_err=0. Reset may arrive mid-shift; the operation is discarded.
- Decode runs every cycle on the stored cw and produces data d, sec_err and ded_err.
  - Syndrome≠0 with overall parity mismatch: single error; flip the indicated bit; sec_err=1.
  - Syndrome=0 with overall parity mismatch: parity-bit error; d unchanged; sec_err=1.
  - Syndrome≠0 with overall parity match: ded_err=1; d = raw data bits.
- serial_out = d[0] when shift_left=0, d[WIDTH-1] when shift_left=1. parallel_out = d.
- Next data when enable=1:
  - 00/01: shift by one, inserting serial_in.
  - 10: load ? parallel_in : shift inserting 0.
  - 11: load ? parallel_in : hold d.
  - load is ignored in modes 00/01.
- Next data when enable=0: hold. This is a commit of d only if scrub_en=1 and sec_err=1 and ded_err=0; otherwise the raw cw is retained unchanged.
- Commit: cw <= encode(next_data). Results are visible on outputs the cycle after the edge (latency 1).
- Injection: cw_next ^= inj_mask when inj_en=1. This applies on top of a commit or a hold.
- sec_cnt: +1, saturating at all-ones, on each cycle where sec_err=1 and a commit occurs. No count when no commit occurs; the error persists and sec_err stays high.
- ded_flag: set on any cycle with ded_err=1. A DED word is never scrubbed; a functional write (enable=1) replaces it.
- err_clr: clears ded_flag and sec_cnt. If a set or increment occurs in the same cycle, the flag ends at 1 and the counter at 1.

Decomposition:
- Package hamming_univ_pkg:
  - mode_e enum (MODE_SISO, MODE_SIPO, MODE_PISO, MODE_PIPO).
  - Function par_bits(width).
  - Parametrised encode function.
  - Position/syndrome constants.
- Sub-module hamming_secded_dec: combinational decoder, WIDTH-parametrised. Inputs cw; outputs d, sec_err, ded_err.

Test Plan (WIDTH=8):
- Reset, then PIPO load 0xA5 -> parallel_out=0xA5 next cycle; sec_err=0, ded_err=0.
- Hold 0xA5 (enable=0, scrub_en=0), inj_mask=13'h0008 (data bit 0) -> parallel_out stays 0xA5, sec_err=1, sec_cnt=0 for several cycles. Then scrub_en=1 -> after one edge sec_err=0, sec_cnt=1.
- inj_mask=13'h0001 (overall parity) -> sec_err=1, data 0xA5 unchanged. After scrub, sec_cnt increments.
- inj_mask=13'h0018 -> ded_err=1, ded_flag=1 and remains set after a PIPO load of 0x3C clears ded_err. err_clr -> ded_flag=0, sec_cnt=0.
- PISO load 0xDB, shift_left=0, 8 shifts -> serial_out sequence 1,1,0,1,1,0,1,1. parallel_out=0x00 at the end.
- SISO from 0 with shift_left=1, serial_in=1 for 3 cycles -> parallel_out=0x07. Assert rst mid-sequence -> all outputs 0 immediately.
